// File: rtl/queue_flow_ctrl.sv
// queue_flow_ctrl: push/pop handshake front-end producing increment/decrement pulses for an occupancy counter.
// Optional statistics counters enabled by QUEUE_FLOW_CTRL_STATS_EN. Revision 1.0
`default_nettype none

module queue_flow_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned STAT_WIDTH    = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic                  pop_valid,
   output logic                  pop_ready,
   input  logic                  cnt_full,
   input  logic                  cnt_empty,
   output logic                  increment,
   output logic                  decrement,
   output logic                  busy,
   output logic                  overflow_err,
   output logic                  underflow_err,
`ifdef QUEUE_FLOW_CTRL_STATS_EN
   output logic [STAT_WIDTH-1:0] push_count,
   output logic [STAT_WIDTH-1:0] pop_count,
`endif
   input  logic                  err_clear
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PULSE  = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] settle_cnt_q, settle_cnt_d;
   logic       rr_prefer_pop_q, rr_prefer_pop_d;
   logic       increment_q, increment_d;
   logic       decrement_q, decrement_d;
   logic       busy_q, busy_d;
   logic       overflow_err_q, overflow_err_d;
   logic       underflow_err_q, underflow_err_d;

   logic is_idle, push_elig, pop_elig, grant_pop, grant_push;
   logic push_fire, pop_fire;

   assign is_idle    = (state_q == ST_IDLE);
   assign push_elig  = push_valid && !cnt_full;
   assign pop_elig   = pop_valid && !cnt_empty;
   assign grant_pop  = pop_elig && (!push_elig || rr_prefer_pop_q);
   assign grant_push = push_elig && !grant_pop;
   assign push_ready = !reset && is_idle && grant_push;
   assign pop_ready  = !reset && is_idle && grant_pop;
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;

   always_comb begin
      state_d         = state_q;
      settle_cnt_d    = settle_cnt_q;
      rr_prefer_pop_d = rr_prefer_pop_q;
      increment_d     = 1'b0;
      decrement_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (push_fire || pop_fire) begin
               state_d         = ST_PULSE;
               increment_d     = push_fire;
               decrement_d     = pop_fire;
               rr_prefer_pop_d = push_fire;
            end
         end
         ST_PULSE: begin
            state_d      = ST_SETTLE;
            settle_cnt_d = 4'(SETTLE_CYCLES - 1);
         end
         ST_SETTLE: begin
            if (settle_cnt_q == 4'd0) begin
               state_d = ST_IDLE;
            end else begin
               settle_cnt_d = settle_cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      // A new error in the same cycle as err_clear must survive the clear.
      overflow_err_d  = (is_idle && push_valid && cnt_full) || (overflow_err_q && !err_clear);
      underflow_err_d = (is_idle && pop_valid && cnt_empty) || (underflow_err_q && !err_clear);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         settle_cnt_q    <= 4'd0;
         rr_prefer_pop_q <= 1'b0;
         increment_q     <= 1'b0;
         decrement_q     <= 1'b0;
         busy_q          <= 1'b0;
         overflow_err_q  <= 1'b0;
         underflow_err_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         settle_cnt_q    <= settle_cnt_d;
         rr_prefer_pop_q <= rr_prefer_pop_d;
         increment_q     <= increment_d;
         decrement_q     <= decrement_d;
         busy_q          <= busy_d;
         overflow_err_q  <= overflow_err_d;
         underflow_err_q <= underflow_err_d;
      end
   end

   assign increment     = increment_q;
   assign decrement     = decrement_q;
   assign busy          = busy_q;
   assign overflow_err  = overflow_err_q;
   assign underflow_err = underflow_err_q;

`ifdef QUEUE_FLOW_CTRL_STATS_EN
   logic [STAT_WIDTH-1:0] push_count_q, push_count_d;
   logic [STAT_WIDTH-1:0] pop_count_q, pop_count_d;

   // Saturating counters: hold at all-ones rather than wrapping.
   always_comb begin
      push_count_d = push_count_q;
      pop_count_d  = pop_count_q;
      if (push_fire && (push_count_q != {STAT_WIDTH{1'b1}})) begin
         push_count_d = push_count_q + 1'b1;
      end
      if (pop_fire && (pop_count_q != {STAT_WIDTH{1'b1}})) begin
         pop_count_d = pop_count_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         push_count_q <= '0;
         pop_count_q  <= '0;
      end else begin
         push_count_q <= push_count_d;
         pop_count_q  <= pop_count_d;
      end
   end

   assign push_count = push_count_q;
   assign pop_count  = pop_count_q;
`endif

endmodule

`default_nettype wire
